// File: rtl/ascii_cell_quantizer_pkg.sv
// Shared constants, types and the luma-to-glyph mapping for the ASCII shader path.
// The glyph renderer imports the same package so both sides agree on the mapping.
package ascii_pkg;

    localparam int DEF_CELL_W     = 8;
    localparam int DEF_CELL_H     = 8;
    localparam int DEF_LUMA_WIDTH = 8;
    localparam int DEF_GLYPH_BITS = 4;

    typedef logic [DEF_LUMA_WIDTH-1:0] luma_t;
    typedef logic [DEF_GLYPH_BITS-1:0] glyph_t;

    // Brighter cells map to higher glyph indices; the low luma bits are dropped.
    function automatic glyph_t luma_to_glyph(input luma_t avg);
        return avg[DEF_LUMA_WIDTH-1 -: DEF_GLYPH_BITS];
    endfunction

endpackage

// File: rtl/ascii_cell_quantizer_band_ram.sv
// Per-column partial-sum store for one cell band: one write port, one
// combinational read port, no reset (contents are rebuilt by each band's first row).
module cell_band_ram #(
    parameter int DEPTH = 80,
    parameter int AW    = 7,
    parameter int DW    = 14
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port: store one completed row-segment sum.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ascii_cell_quantizer.sv
// Averages a raster luminance stream over CELL_W x CELL_H cells and emits one
// glyph index per cell with its coordinates, using valid/ready on both sides.
module ascii_cell_quantizer
    import ascii_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CELL_W     = DEF_CELL_W,
    parameter int CELL_H     = DEF_CELL_H,
    parameter int LUMA_WIDTH = DEF_LUMA_WIDTH,
    parameter int GLYPH_BITS = DEF_GLYPH_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [LUMA_WIDTH-1:0]                  in_luma,
    input  logic                                   in_sof,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [GLYPH_BITS-1:0]                  out_glyph,
    output logic [$clog2(IMG_WIDTH/CELL_W)-1:0]    out_cell_x,
    output logic [$clog2(IMG_HEIGHT/CELL_H)-1:0]   out_cell_y,
    output logic                                   out_last,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int CELLS_X   = IMG_WIDTH / CELL_W;
    localparam int CELLS_Y   = IMG_HEIGHT / CELL_H;
    localparam int CX_W      = $clog2(CELLS_X);
    localparam int CY_W      = $clog2(CELLS_Y);
    localparam int PX_W      = $clog2(CELL_W);
    localparam int LY_W      = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int AVG_SHIFT = $clog2(CELL_W * CELL_H);
    localparam int SW        = LUMA_WIDTH + AVG_SHIFT;

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_W - 1);
    localparam logic [LY_W-1:0] LY_LAST = LY_W'(CELL_H - 1);
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(CELLS_X - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(CELLS_Y - 1);
    localparam logic [PX_W-1:0] PX_ONE  = PX_W'(1);
    localparam logic [LY_W-1:0] LY_ONE  = LY_W'(1);
    localparam logic [CX_W-1:0] CX_ONE  = CX_W'(1);
    localparam logic [CY_W-1:0] CY_ONE  = CY_W'(1);

    logic [PX_W-1:0]       px_r, px_s, px_nxt_s;
    logic [CX_W-1:0]       cx_r, cx_s, cx_nxt_s;
    logic [LY_W-1:0]       ly_r, ly_s, ly_nxt_s;
    logic [CY_W-1:0]       cy_r, cy_s, cy_nxt_s;
    logic [SW-1:0]         sum_r, sum_nxt_s, luma_ext_s, acc_rd_s;
    logic [LUMA_WIDTH-1:0] avg_s;
    logic [GLYPH_BITS-1:0] glyph_s;
    logic                  accept_s, row_end_s, cell_done_s, acc_we_s, last_cell_s;

    assign in_ready    = !out_valid || out_ready;
    assign accept_s    = in_valid && in_ready;
    assign row_end_s   = (px_s == PX_LAST);
    assign cell_done_s = accept_s && row_end_s && (ly_s == LY_LAST);
    assign acc_we_s    = accept_s && row_end_s && (ly_s != LY_LAST);
    assign last_cell_s = (cx_s == CX_LAST) && (cy_s == CY_LAST);
    assign luma_ext_s  = {{AVG_SHIFT{1'b0}}, in_luma};
    assign avg_s       = sum_nxt_s[SW-1:AVG_SHIFT];
    assign glyph_s     = avg_s[LUMA_WIDTH-1 -: GLYPH_BITS];

    // Effective position of the incoming pixel: sof forces the frame origin.
    always_comb begin
        px_s = px_r;
        cx_s = cx_r;
        ly_s = ly_r;
        cy_s = cy_r;
        if (in_sof) begin
            px_s = {PX_W{1'b0}};
            cx_s = {CX_W{1'b0}};
            ly_s = {LY_W{1'b0}};
            cy_s = {CY_W{1'b0}};
        end else begin
            px_s = px_r;
            cx_s = cx_r;
            ly_s = ly_r;
            cy_s = cy_r;
        end
    end

    // Raster-order advance of the four position counters.
    always_comb begin
        px_nxt_s = px_s;
        cx_nxt_s = cx_s;
        ly_nxt_s = ly_s;
        cy_nxt_s = cy_s;
        if (row_end_s) begin
            px_nxt_s = {PX_W{1'b0}};
            if (cx_s == CX_LAST) begin
                cx_nxt_s = {CX_W{1'b0}};
                if (ly_s == LY_LAST) begin
                    ly_nxt_s = {LY_W{1'b0}};
                    if (cy_s == CY_LAST) begin
                        cy_nxt_s = {CY_W{1'b0}};
                    end else begin
                        cy_nxt_s = cy_s + CY_ONE;
                    end
                end else begin
                    ly_nxt_s = ly_s + LY_ONE;
                end
            end else begin
                cx_nxt_s = cx_s + CX_ONE;
            end
        end else begin
            px_nxt_s = px_s + PX_ONE;
        end
    end

    // Running sum: first-row/first-column loads overwrite, so stale partials vanish.
    always_comb begin
        sum_nxt_s = sum_r + luma_ext_s;
        if (px_s == {PX_W{1'b0}}) begin
            if (ly_s == {LY_W{1'b0}}) begin
                sum_nxt_s = luma_ext_s;
            end else begin
                sum_nxt_s = acc_rd_s + luma_ext_s;
            end
        end else begin
            sum_nxt_s = sum_r + luma_ext_s;
        end
    end

    cell_band_ram #(
        .DEPTH (CELLS_X),
        .AW    (CX_W),
        .DW    (SW)
    ) u_band_ram (
        .clk     (clk),
        .wr_en   (acc_we_s),
        .wr_addr (cx_s),
        .wr_data (sum_nxt_s),
        .rd_addr (cx_s),
        .rd_data (acc_rd_s)
    );

    // Position counters and running sum advance only on an accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_r  <= {PX_W{1'b0}};
            cx_r  <= {CX_W{1'b0}};
            ly_r  <= {LY_W{1'b0}};
            cy_r  <= {CY_W{1'b0}};
            sum_r <= {SW{1'b0}};
        end else if (accept_s) begin
            px_r  <= px_nxt_s;
            cx_r  <= cx_nxt_s;
            ly_r  <= ly_nxt_s;
            cy_r  <= cy_nxt_s;
            sum_r <= sum_nxt_s;
        end
    end

    // Output register: a completing cell reloads it even in the handshake cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_glyph  <= {GLYPH_BITS{1'b0}};
            out_cell_x <= {CX_W{1'b0}};
            out_cell_y <= {CY_W{1'b0}};
            out_last   <= 1'b0;
        end else if (cell_done_s) begin
            out_valid  <= 1'b1;
            out_glyph  <= glyph_s;
            out_cell_x <= cx_s;
            out_cell_y <= cy_s;
            out_last   <= last_cell_s;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
